// File: rtl/pm_entry_pkg.sv
// Shared encodings for the PM entry controller: link state request/status
// codes and the handshake FSM state enum.
package pm_entry_pkg;

  // Adapter state request / link status encodings (4-bit native form).
  localparam logic [3:0] ST_RESET  = 4'b0000;
  localparam logic [3:0] ST_ACTIVE = 4'b0001;
  localparam logic [3:0] ST_L1     = 4'b0100;
  localparam logic [3:0] ST_L2     = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_STALL,
    S_SB_REQ,
    S_WAIT_RSP,
    S_PM,
    S_NAK
  } pm_state_e;

endpackage

// File: rtl/pm_timeout_counter.sv
// Response wait timer: cleared before a wait starts, counts enabled cycles
// and flags the last permitted cycle so the FSM can give up on the peer.
module pm_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count up while enabled, saturating on the last cycle of the window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/pm_entry_ctrl.sv
// PM entry controller: moves the link from ACTIVE into L1/L2 by stalling
// the adapter, sending one sideband PM request and waiting for the peer's
// accept/reject, falling back to NAK on reject or on response timeout.
module pm_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STS_WIDTH      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [STS_WIDTH-1:0] i_lp_state_req,
  input  logic                 i_lp_stallack,
  input  logic                 i_sb_pm_rsp_valid,
  input  logic                 i_sb_pm_rsp_ack,
  output logic                 o_pl_stallreq,
  output logic                 o_sb_pm_req_valid,
  output logic [STS_WIDTH-1:0] o_sb_pm_req_state,
  output logic [STS_WIDTH-1:0] o_pl_state_sts,
  output logic                 o_pl_nak
);

  import pm_entry_pkg::*;

  localparam logic [STS_WIDTH-1:0] REQ_RESET  = STS_WIDTH'(ST_RESET);
  localparam logic [STS_WIDTH-1:0] REQ_ACTIVE = STS_WIDTH'(ST_ACTIVE);
  localparam logic [STS_WIDTH-1:0] REQ_L1     = STS_WIDTH'(ST_L1);
  localparam logic [STS_WIDTH-1:0] REQ_L2     = STS_WIDTH'(ST_L2);

  pm_state_e            state;
  logic [STS_WIDTH-1:0] target;
  logic                 timer_expired;

  // Timer is zeroed while the request strobe is out, so it reads 0 on the
  // first WAIT_RSP cycle and advances once per cycle without a response.
  pm_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (state == S_SB_REQ),
    .enable (state == S_WAIT_RSP),
    .expired(timer_expired)
  );

  // Handshake FSM; every output is computed alongside the next state so
  // it is a flop and changes on the same edge as the state it belongs to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: async reset clears state and outputs at once, so a handshake in
    // flight is dropped without waiting for a clock edge.
    if (i_rst) begin
      state             <= S_IDLE;
      target            <= '0;
      o_pl_stallreq     <= 1'b0;
      o_sb_pm_req_valid <= 1'b0;
      o_sb_pm_req_state <= '0;
      o_pl_state_sts    <= '0;
      o_pl_nak          <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments
      // in the same block; this keeps the request strobe one cycle wide.
      o_sb_pm_req_valid <= 1'b0;
      if (state != S_IDLE && i_lp_state_req == REQ_RESET) begin
        state             <= S_IDLE;
        target            <= '0;
        o_pl_stallreq     <= 1'b0;
        o_sb_pm_req_state <= '0;
        o_pl_state_sts    <= '0;
        o_pl_nak          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_lp_state_req == REQ_ACTIVE) begin
              state          <= S_ACTIVE;
              o_pl_state_sts <= REQ_ACTIVE;
            end
          end
          S_ACTIVE: begin
            if (i_lp_state_req == REQ_L1 || i_lp_state_req == REQ_L2) begin
              state         <= S_STALL;
              target        <= i_lp_state_req;
              o_pl_stallreq <= 1'b1;
            end
          end
          S_STALL: begin
            if (i_lp_stallack) begin
              state             <= S_SB_REQ;
              o_sb_pm_req_valid <= 1'b1;
              o_sb_pm_req_state <= target;
            end else if (i_lp_state_req == REQ_ACTIVE) begin
              state         <= S_ACTIVE;
              o_pl_stallreq <= 1'b0;
            end
          end
          S_SB_REQ: begin
            state <= S_WAIT_RSP;
          end
          S_WAIT_RSP: begin
            // A response wins over an expiry landing on the same cycle.
            if (i_sb_pm_rsp_valid && i_sb_pm_rsp_ack) begin
              state          <= S_PM;
              o_pl_state_sts <= target;
            end else if (i_sb_pm_rsp_valid || timer_expired) begin
              state         <= S_NAK;
              o_pl_nak      <= 1'b1;
              o_pl_stallreq <= 1'b0;
            end
          end
          S_PM: begin
            if (i_lp_state_req == REQ_ACTIVE) begin
              state          <= S_ACTIVE;
              o_pl_stallreq  <= 1'b0;
              o_pl_state_sts <= REQ_ACTIVE;
            end
          end
          S_NAK: begin
            if (!i_lp_stallack && i_lp_state_req == REQ_ACTIVE) begin
              state    <= S_ACTIVE;
              o_pl_nak <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
